// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
package regfile_pkg;

    localparam int unsigned ADDRSIZE_DEF = 5;
    localparam int unsigned WORDSIZE_DEF = 64;
    localparam int unsigned ZERO_REG     = 0;

    typedef logic [ADDRSIZE_DEF-1:0] reg_addr_t;
    typedef logic [WORDSIZE_DEF-1:0] reg_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the priority pointer.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned j;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr_q) + k) % NREQ;
            if (en && !found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

    // The pointer moves only on a completed transfer, so a hold leaves it untouched.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NREQ writeback sources, round-robin,
// with a registered output stage and silent absorption of x0 writes.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
    parameter int unsigned WORDSIZE = WORDSIZE_DEF,
    parameter int unsigned NREQ     = 2,
    localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDRSIZE-1:0] req_rd,
    input  logic [NREQ*WORDSIZE-1:0] req_data,
    output logic                     regwr,
    output logic [ADDRSIZE-1:0]      rd,
    output logic [WORDSIZE-1:0]      rddata,
    output logic [IDW-1:0]           grant_id
);

    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                transfer;
    logic [ADDRSIZE-1:0] sel_rd;
    logic [WORDSIZE-1:0] sel_data;

    logic                regwr_q, regwr_d;
    logic [ADDRSIZE-1:0] rd_q, rd_d;
    logic [WORDSIZE-1:0] rddata_q, rddata_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (!hold),
        .advance (transfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign req_ready = gnt;
    assign transfer  = |gnt;
    assign sel_rd    = req_rd[gnt_idx*ADDRSIZE +: ADDRSIZE];
    assign sel_data  = req_data[gnt_idx*WORDSIZE +: WORDSIZE];

    always_comb begin
        regwr_d    = 1'b0;
        rd_d       = rd_q;
        rddata_d   = rddata_q;
        grant_id_d = grant_id_q;
        if (transfer) begin
            regwr_d    = (sel_rd != ADDRSIZE'(ZERO_REG));
            rd_d       = sel_rd;
            rddata_d   = sel_data;
            grant_id_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwr_q    <= 1'b0;
            rd_q       <= '0;
            rddata_q   <= '0;
            grant_id_q <= '0;
        end else begin
            regwr_q    <= regwr_d;
            rd_q       <= rd_d;
            rddata_q   <= rddata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign regwr    = regwr_q;
    assign rd       = rd_q;
    assign rddata   = rddata_q;
    assign grant_id = grant_id_q;

endmodule
